mdu_iter: RTL and testbench

- Parametrised multiply/divide unit that replaces the fixed single-purpose MDU in the EX stage.
- Accepts one MULT/MULTU/DIV/DIVU operation through a start/in_ready handshake.
- Multiplies in a counted MUL_STAGES-cycle pipeline; divides with a WIDTH-iteration radix-2 restoring divider.
- Returns {hi,lo} with a one-cycle out_valid pulse. Supports cancel, used on pipeline flush or exception.

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu_iter_if.sv | 26 ++
 rtl/div_core.sv | 70 +++++++
 rtl/mdu_iter.sv | 164 ++++++++++++++++
 tb/tb_mdu_iter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings and sizing helpers for the iterative multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StFix
    } mdu_state_e;

    localparam int unsigned DefWidth = 32;
    localparam int unsigned DefCntW  = $clog2(DefWidth + 1);

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface mdu_iter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             in_ready;
    logic             busy;
    logic             out_valid;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, a, b, cancel,
        input  in_ready, busy, out_valid, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b, cancel,
        output in_ready, busy, out_valid, hi, lo, div_by_zero
    );
endinterface

// File: rtl/div_core.sv
// Radix-2 restoring divider on unsigned magnitudes: one quotient bit per step.
module div_core
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             step_done
);
    localparam int unsigned     CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_comb begin
        shifted = {rem_q, quot_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        rem_d   = rem_q;
        quot_d  = quot_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        if (load) begin
            rem_d  = '0;
            quot_d = dividend;
            dvs_d  = divisor;
            cnt_d  = '0;
        end else if (step) begin
            // Trial subtract; keep the shifted remainder when it would go negative.
            if (!trial[WIDTH]) begin
                rem_d  = trial[WIDTH-1:0];
                quot_d = {quot_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d  = shifted[WIDTH-1:0];
                quot_d = {quot_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
        end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
        end
    end

    assign quot      = quot_q;
    assign rem       = rem_q;
    assign step_done = step && !load && (cnt_q == LastCnt);

endmodule

// File: rtl/mdu_iter.sv
// Multiply/divide unit: counted multiply latency, iterative divide, sign fixup
// on magnitudes, single-cycle result pulse with cancel support.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_STAGES = 2
) (
    input logic       clk,
    input logic       rst,
    mdu_iter_if.slave bus
);
    localparam int unsigned     CntW   = cnt_width(WIDTH);
    localparam logic [CntW-1:0] MulCnt = CntW'(MUL_STAGES);

    mdu_state_e       state_q, state_d;
    logic [WIDTH-1:0] mag_a_q, mag_a_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic             zero_b_q, zero_b_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic             op_signed;
    logic             op_div;
    logic             a_neg_in, b_neg_in;
    logic [WIDTH-1:0] mag_a_in, mag_b_in;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quot, rem, quot_fix, rem_fix;
    logic             div_load, div_step, div_done;

    assign accept    = bus.start && (state_q == StIdle) && !bus.cancel;
    assign op_signed = !bus.op[0];
    assign op_div    = bus.op[1];
    assign a_neg_in  = op_signed && bus.a[WIDTH-1];
    assign b_neg_in  = op_signed && bus.b[WIDTH-1];
    assign mag_a_in  = a_neg_in ? -bus.a : bus.a;
    assign mag_b_in  = b_neg_in ? -bus.b : bus.b;

    // Most-negative / -1 needs no special case: the magnitude quotient is
    // 2^(WIDTH-1), and negating it wraps back to the most-negative value.
    assign prod     = {{WIDTH{1'b0}}, mag_a_q} * {{WIDTH{1'b0}}, mag_b_q};
    assign prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;
    assign quot_fix = (neg_a_q ^ neg_b_q) ? -quot : quot;
    assign rem_fix  = neg_a_q ? -rem : rem;

    always_comb begin
        state_d     = state_q;
        mag_a_d     = mag_a_q;
        mag_b_d     = mag_b_q;
        neg_a_d     = neg_a_q;
        neg_b_d     = neg_b_q;
        zero_b_d    = zero_b_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        hi_d        = hi_q;
        lo_d        = lo_q;
        dbz_d       = dbz_q;
        div_load    = 1'b0;
        div_step    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    mag_a_d  = mag_a_in;
                    mag_b_d  = mag_b_in;
                    neg_a_d  = a_neg_in;
                    neg_b_d  = b_neg_in;
                    zero_b_d = (bus.b == '0);
                    cnt_d    = '0;
                    dbz_d    = 1'b0;
                    div_load = op_div;
                    state_d  = op_div ? StDiv : StMul;
                end
            end
            StMul: begin
                cnt_d = cnt_q + CntW'(1);
                if (cnt_d == MulCnt) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b1;
                    hi_d        = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d        = prod_fix[WIDTH-1:0];
                end
            end
            StDiv: begin
                div_step = 1'b1;
                if (div_done) state_d = StFix;
            end
            StFix: begin
                state_d     = StIdle;
                out_valid_d = 1'b1;
                // A zero divisor leaves the dividend in rem, so rem_fix restores a.
                hi_d        = rem_fix;
                lo_d        = zero_b_q ? '1 : quot_fix;
                dbz_d       = zero_b_q;
            end
            default: state_d = StIdle;
        endcase

        if (bus.cancel) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            hi_d        = hi_q;
            lo_d        = lo_q;
            dbz_d       = dbz_q;
            div_step    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            mag_a_q     <= '0;
            mag_b_q     <= '0;
            neg_a_q     <= 1'b0;
            neg_b_q     <= 1'b0;
            zero_b_q    <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mag_a_q     <= mag_a_d;
            mag_b_q     <= mag_b_d;
            neg_a_q     <= neg_a_d;
            neg_b_q     <= neg_b_d;
            zero_b_q    <= zero_b_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            dbz_q       <= dbz_d;
        end
    end

    div_core #(
        .WIDTH(WIDTH)
    ) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load),
        .step      (div_step),
        .dividend  (mag_a_in),
        .divisor   (mag_b_in),
        .quot      (quot),
        .rem       (rem),
        .step_done (div_done)
    );

    assign bus.in_ready    = (state_q == StIdle);
    assign bus.busy        = (state_q != StIdle);
    assign bus.out_valid   = out_valid_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: a 32-bit/2-stage instance and a 16-bit/4-stage instance.
module tb_mdu_iter;
    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   lat;
    int   seen;

    mdu_iter_if #(.WIDTH(32)) b32 ();
    mdu_iter_if #(.WIDTH(16)) b16 ();

    mdu_iter #(.WIDTH(32), .MUL_STAGES(2)) u_dut32 (.clk(clk), .rst(rst), .bus(b32));
    mdu_iter #(.WIDTH(16), .MUL_STAGES(4)) u_dut16 (.clk(clk), .rst(rst), .bus(b16));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called one step after an edge (in cycle T); returns in cycle T+1.
    task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        b32.start = 1'b1;
        b32.op    = op;
        b32.a     = a;
        b32.b     = b;
        step_cycle();
        b32.start = 1'b0;
    endtask

    task automatic issue16(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        b16.start = 1'b1;
        b16.op    = op;
        b16.a     = a;
        b16.b     = b;
        step_cycle();
        b16.start = 1'b0;
    endtask

    // Returns the cycle offset from the accept cycle at which out_valid was seen (60 = timeout).
    task automatic wait32(output int l);
        l = 1;
        while (!b32.out_valid && l < 60) begin
            step_cycle();
            l++;
        end
    endtask

    task automatic wait16(output int l);
        l = 1;
        while (!b16.out_valid && l < 60) begin
            step_cycle();
            l++;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        clk = 1'b0;
        rst = 1'b0;
        b32.start = 1'b0; b32.op = 2'b00; b32.a = '0; b32.b = '0; b32.cancel = 1'b0;
        b16.start = 1'b0; b16.op = 2'b00; b16.a = '0; b16.b = '0; b16.cancel = 1'b0;
        repeat (2) step_cycle();

        check("rst_in_ready", b32.in_ready, 1);
        check("rst_busy", b32.busy, 0);
        check("rst_out_valid", b32.out_valid, 0);
        check("rst_hi", b32.hi, 0);
        check("rst_lo", b32.lo, 0);
        check("rst_dbz", b32.div_by_zero, 0);
        rst = 1'b1;
        step_cycle();

        // MULT -3 * 5
        issue32(2'b00, 32'hFFFF_FFFD, 32'h0000_0005);
        check("mult_busy", b32.busy, 1);
        wait32(lat);
        check("mult_lat", lat, 3);
        check("mult_hi", b32.hi, 32'hFFFF_FFFF);
        check("mult_lo", b32.lo, 32'hFFFF_FFF1);
        check("mult_in_ready", b32.in_ready, 1);
        step_cycle();
        check("mult_pulse_once", b32.out_valid, 0);

        // MULTU max*max, then DIVU accepted in the out_valid cycle
        issue32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait32(lat);
        check("multu_lat", lat, 3);
        check("multu_hi", b32.hi, 32'hFFFF_FFFE);
        check("multu_lo", b32.lo, 32'h0000_0001);
        issue32(2'b11, 32'd100, 32'd7);
        wait32(lat);
        check("b2b_divu_lat", lat, 34);
        check("b2b_divu_lo", b32.lo, 32'h0000_000E);
        check("b2b_divu_hi", b32.hi, 32'h0000_0002);
        step_cycle();
        check("divu_pulse_once", b32.out_valid, 0);

        // Signed divides
        issue32(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        wait32(lat);
        check("div_neg_lat", lat, 34);
        check("div_neg_lo", b32.lo, 32'hFFFF_FFFD);
        check("div_neg_hi", b32.hi, 32'hFFFF_FFFF);
        step_cycle();
        issue32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait32(lat);
        check("div_ovf_lat", lat, 34);
        check("div_ovf_lo", b32.lo, 32'h8000_0000);
        check("div_ovf_hi", b32.hi, 32'h0000_0000);
        check("div_ovf_dbz", b32.div_by_zero, 0);
        step_cycle();

        // Divide by zero
        issue32(2'b11, 32'h0000_0064, 32'h0000_0000);
        wait32(lat);
        check("divu0_lat", lat, 34);
        check("divu0_lo", b32.lo, 32'hFFFF_FFFF);
        check("divu0_hi", b32.hi, 32'h0000_0064);
        check("divu0_dbz", b32.div_by_zero, 1);
        step_cycle();
        check("dbz_holds", b32.div_by_zero, 1);
        issue32(2'b10, 32'hFFFF_FFF9, 32'h0000_0000);
        wait32(lat);
        check("div0_lat", lat, 34);
        check("div0_lo", b32.lo, 32'hFFFF_FFFF);
        check("div0_hi", b32.hi, 32'hFFFF_FFF9);
        check("div0_dbz", b32.div_by_zero, 1);
        step_cycle();
        issue32(2'b01, 32'd3, 32'd4);
        check("dbz_cleared_on_accept", b32.div_by_zero, 0);
        wait32(lat);
        check("multu34_lat", lat, 3);
        check("multu34_lo", b32.lo, 32'h0000_000C);
        check("multu34_hi", b32.hi, 32'h0000_0000);
        step_cycle();

        // Cancel at T+10 of a divide
        issue32(2'b10, 32'd1000, 32'd3);
        repeat (9) step_cycle();
        b32.cancel = 1'b1;
        step_cycle();
        b32.cancel = 1'b0;
        check("cancel_in_ready", b32.in_ready, 1);
        check("cancel_busy", b32.busy, 0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (b32.out_valid) seen++;
            step_cycle();
        end
        check("cancel_no_valid", seen, 0);
        check("cancel_hi_kept", b32.hi, 32'h0000_0000);
        check("cancel_lo_kept", b32.lo, 32'h0000_000C);

        // start together with cancel in IDLE is dropped
        b32.cancel = 1'b1;
        issue32(2'b01, 32'd5, 32'd6);
        b32.cancel = 1'b0;
        check("start_cancel_in_ready", b32.in_ready, 1);
        check("start_cancel_busy", b32.busy, 0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (b32.out_valid) seen++;
            step_cycle();
        end
        check("start_cancel_no_valid", seen, 0);

        // Reset mid-divide
        issue32(2'b10, 32'd1000, 32'd3);
        repeat (4) step_cycle();
        rst = 1'b0;
        #1;
        check("midrst_in_ready", b32.in_ready, 1);
        check("midrst_busy", b32.busy, 0);
        check("midrst_hi", b32.hi, 0);
        check("midrst_lo", b32.lo, 0);
        check("midrst_dbz", b32.div_by_zero, 0);
        repeat (2) step_cycle();
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (b32.out_valid) seen++;
            step_cycle();
        end
        check("midrst_no_valid", seen, 0);

        // 16-bit, 4-stage instance
        issue16(2'b00, 16'h8000, 16'h8000);
        wait16(lat);
        check("w16_mult_lat", lat, 5);
        check("w16_mult_hi", b16.hi, 16'h4000);
        check("w16_mult_lo", b16.lo, 16'h0000);
        step_cycle();
        issue16(2'b10, 16'h8000, 16'hFFFF);
        wait16(lat);
        check("w16_div_ovf_lat", lat, 18);
        check("w16_div_ovf_lo", b16.lo, 16'h8000);
        check("w16_div_ovf_hi", b16.hi, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
